// File: rtl/ctrl_decode_queue.sv
// rtl/ctrl_decode_queue.sv - RV32 main-control decoder feeding a DEPTH-entry fetch-to-execute queue
// Optional illegal-opcode flagging is enabled by defining DECODE_ILLEGAL_EN.
module ctrl_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [31:0]              IN_INSTR,
  input  logic [PC_W-1:0]          IN_PC,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [11:0]              OUT_CTRL,
  output logic [31:0]              OUT_INSTR,
  output logic [PC_W-1:0]          OUT_PC,
  output logic                     OUT_ILLEGAL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Control bundle field positions, bit 11 = J0 down to EXTOP in [2:0].
  localparam logic [11:0] F_J0 = 12'h800;
  localparam logic [11:0] F_J1 = 12'h400;
  localparam logic [11:0] F_B  = 12'h200;
  localparam logic [11:0] F_U0 = 12'h100;
  localparam logic [11:0] F_U1 = 12'h080;
  localparam logic [11:0] F_RW = 12'h040;
  localparam logic [11:0] F_MW = 12'h020;
  localparam logic [11:0] F_MT = 12'h010;
  localparam logic [11:0] F_RS = 12'h008;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [11:0]      ctrl_mem  [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [11:0]      dec_ctrl;
  logic             push;
  logic             pop;

`ifdef DECODE_ILLEGAL_EN
  logic             dec_illegal;
  logic             ill_mem [DEPTH];
`endif

  always_comb begin
    dec_ctrl = '0;
`ifdef DECODE_ILLEGAL_EN
    dec_illegal = 1'b0;
`endif
    case (IN_INSTR[6:0])
      7'b0000011: dec_ctrl = F_RW | F_MT | F_RS;
      7'b0100011: dec_ctrl = F_MW | F_RS | 12'h002;
      7'b0110011: dec_ctrl = F_RW;
      7'b0010011: dec_ctrl = F_RW | F_RS;
      7'b1100011: dec_ctrl = F_B | 12'h003;
      7'b1101111: dec_ctrl = F_J0 | F_RW | 12'h004;
      7'b1100111: dec_ctrl = F_J1 | F_RW | F_RS;
      7'b0110111: dec_ctrl = F_U0 | F_RW | 12'h001;
      7'b0010111: dec_ctrl = F_U1 | F_RW | 12'h001;
      default: begin
        dec_ctrl = '0;
`ifdef DECODE_ILLEGAL_EN
        // Every table opcode ends in 2'b11, so compressed-looking words land here too.
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign IN_READY  = (count_q < CNT_W'(DEPTH));
  assign OUT_VALID = (count_q != '0);
  assign COUNT     = count_q;

  assign push = IN_VALID & IN_READY & ~FLUSH;
  assign pop  = OUT_VALID & OUT_READY & ~FLUSH;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the empty-queue output gating hides stale contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      ctrl_mem[wr_ptr_q]  <= dec_ctrl;
      instr_mem[wr_ptr_q] <= IN_INSTR;
      pc_mem[wr_ptr_q]    <= IN_PC;
`ifdef DECODE_ILLEGAL_EN
      ill_mem[wr_ptr_q]   <= dec_illegal;
`endif
    end
  end

  assign OUT_CTRL  = OUT_VALID ? ctrl_mem[rd_ptr_q]  : '0;
  assign OUT_INSTR = OUT_VALID ? instr_mem[rd_ptr_q] : '0;
  assign OUT_PC    = OUT_VALID ? pc_mem[rd_ptr_q]    : '0;

`ifdef DECODE_ILLEGAL_EN
  assign OUT_ILLEGAL = OUT_VALID ? ill_mem[rd_ptr_q] : 1'b0;
`else
  assign OUT_ILLEGAL = 1'b0;
`endif

endmodule
